mem_port_arbiter: RTL

- Shares one valid/ack memory port between the core's instruction fetch port (imem, read-only) and data port (dmem, read/write with byte selects).
- Sits between the core's imem_*/dmem_* ports and a single-ported memory or bus.
- Serialises requests with a selectable priority policy (round-robin or fixed dmem-first).
- A watchdog terminates hung transactions with an error response.

---
 rtl/atom_bus_pkg.sv | 25 ++
 rtl/bus_watchdog.sv | 39 +++
 rtl/mem_port_arbiter.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/atom_bus_pkg.sv
// Shared encodings for the memory port arbiter: FSM states, owner IDs and
// the request bundle that is latched onto the shared port.
package atom_bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2
    } arb_state_e;

    typedef enum logic {
        OWN_IMEM = 1'b0,
        OWN_DMEM = 1'b1
    } owner_e;

    localparam logic [3:0] SEL_ALL = 4'b1111;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  sel;
        logic        we;
    } mem_req_t;

endpackage

// File: rtl/bus_watchdog.sv
// Cycle counter for an outstanding shared-port request. Counts while enabled,
// clears between transactions, and flags expiry on the last allowed cycle.
// A zero limit disables expiry entirely.
module bus_watchdog #(
    parameter int TO_W = 16
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            clr_i,
    input  logic            en_i,
    input  logic [TO_W-1:0] limit_i,
    output logic            expire_o
);

    logic [TO_W-1:0] cnt_q, cnt_d;

    // Next count: clear wins over enable.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Counter register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Expire in the cycle the request has been outstanding for limit cycles.
    assign expire_o = en_i && (limit_i != '0) && (cnt_q == limit_i - 1'b1);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the core's fetch (imem) and data (dmem) ports onto one shared
// valid/ack memory port. One transaction at a time: IDLE picks a winner,
// REQ waits for ack or watchdog expiry, RESP pulses the requester's ack.
module mem_port_arbiter
    import atom_bus_pkg::*;
#(
    parameter bit RR_ENABLE      = 1'b1,
    parameter int TIMEOUT_CYCLES = 0,
    parameter int TO_W           = 16
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] imem_addr_i,
    input  logic        imem_valid_i,
    output logic [31:0] imem_data_o,
    output logic        imem_ack_o,
    output logic        imem_err_o,
    input  logic [31:0] dmem_addr_i,
    input  logic [31:0] dmem_data_i,
    input  logic [3:0]  dmem_sel_i,
    input  logic        dmem_we_i,
    input  logic        dmem_valid_i,
    output logic [31:0] dmem_data_o,
    output logic        dmem_ack_o,
    output logic        dmem_err_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_data_o,
    output logic [3:0]  mem_sel_o,
    output logic        mem_we_o,
    output logic        mem_valid_o,
    input  logic [31:0] mem_data_i,
    input  logic        mem_ack_i
);

    arb_state_e  state_q, state_d;
    owner_e      owner_q, owner_d;
    owner_e      last_q, last_d;
    mem_req_t    req_q, req_d;
    logic        mem_valid_q, mem_valid_d;
    logic [31:0] imem_data_q, imem_data_d;
    logic [31:0] dmem_data_q, dmem_data_d;
    logic        imem_ack_q, imem_ack_d, imem_err_q, imem_err_d;
    logic        dmem_ack_q, dmem_ack_d, dmem_err_q, dmem_err_d;

    owner_e      win;
    mem_req_t    imem_req, dmem_req;
    logic        wd_expire;
    logic [31:0] rdata;
    logic        rerr;

    // Fetches always read whole words.
    assign imem_req = '{addr: imem_addr_i, data: 32'h0, sel: SEL_ALL, we: 1'b0};
    assign dmem_req = '{addr: dmem_addr_i, data: dmem_data_i, sel: dmem_sel_i, we: dmem_we_i};

    bus_watchdog #(.TO_W(TO_W)) u_wd (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .clr_i    (state_q != ST_REQ),
        .en_i     (state_q == ST_REQ),
        .limit_i  (TO_W'(TIMEOUT_CYCLES)),
        .expire_o (wd_expire)
    );

    // Winner selection: on a tie, round-robin favours whoever did not win last.
    always_comb begin
        if (imem_valid_i && dmem_valid_i) begin
            if (RR_ENABLE) begin
                win = (last_q == OWN_IMEM) ? OWN_DMEM : OWN_IMEM;
            end else begin
                win = OWN_DMEM;
            end
        end else if (dmem_valid_i) begin
            win = OWN_DMEM;
        end else begin
            win = OWN_IMEM;
        end
    end

    // Completion payload: a real ack returns memory data, expiry returns zero + err.
    assign rdata = mem_ack_i ? mem_data_i : 32'h0;
    assign rerr  = !mem_ack_i;

    // Next-state and output logic; acks default low so they last one cycle.
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        last_d      = last_q;
        req_d       = req_q;
        mem_valid_d = mem_valid_q;
        imem_data_d = imem_data_q;
        dmem_data_d = dmem_data_q;
        imem_ack_d  = 1'b0;
        imem_err_d  = 1'b0;
        dmem_ack_d  = 1'b0;
        dmem_err_d  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (imem_valid_i || dmem_valid_i) begin
                    owner_d     = win;
                    last_d      = win;
                    req_d       = (win == OWN_DMEM) ? dmem_req : imem_req;
                    mem_valid_d = 1'b1;
                    state_d     = ST_REQ;
                end
            end
            ST_REQ: begin
                if (mem_ack_i || wd_expire) begin
                    mem_valid_d = 1'b0;
                    state_d     = ST_RESP;
                    if (owner_q == OWN_DMEM) begin
                        dmem_data_d = rdata;
                        dmem_ack_d  = 1'b1;
                        dmem_err_d  = rerr;
                    end else begin
                        imem_data_d = rdata;
                        imem_ack_d  = 1'b1;
                        imem_err_d  = rerr;
                    end
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset abandons any transaction in flight.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            owner_q     <= OWN_IMEM;
            last_q      <= OWN_IMEM;
            req_q       <= '0;
            mem_valid_q <= 1'b0;
            imem_data_q <= 32'h0;
            dmem_data_q <= 32'h0;
            imem_ack_q  <= 1'b0;
            imem_err_q  <= 1'b0;
            dmem_ack_q  <= 1'b0;
            dmem_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            last_q      <= last_d;
            req_q       <= req_d;
            mem_valid_q <= mem_valid_d;
            imem_data_q <= imem_data_d;
            dmem_data_q <= dmem_data_d;
            imem_ack_q  <= imem_ack_d;
            imem_err_q  <= imem_err_d;
            dmem_ack_q  <= dmem_ack_d;
            dmem_err_q  <= dmem_err_d;
        end
    end

    assign mem_addr_o  = req_q.addr;
    assign mem_data_o  = req_q.data;
    assign mem_sel_o   = req_q.sel;
    assign mem_we_o    = req_q.we;
    assign mem_valid_o = mem_valid_q;
    assign imem_data_o = imem_data_q;
    assign imem_ack_o  = imem_ack_q;
    assign imem_err_o  = imem_err_q;
    assign dmem_data_o = dmem_data_q;
    assign dmem_ack_o  = dmem_ack_q;
    assign dmem_err_o  = dmem_err_q;

endmodule
